// File: rtl/divide.sv
// Iterative restoring divider, one quotient bit per clock.
// Level-held div_begin / div_end handshake shared with the multiply unit.
// Optional macro DIV_SIGNED_EN: treat operands as two's complement; the
// unsigned core runs on magnitudes and signs are restored on completion.
// Without the macro the unit is purely unsigned.
module divide #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_begin,
   input  logic [WIDTH-1:0] div_op1,
   input  logic [WIDTH-1:0] div_op2,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             div_end
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state, next_state;

   // The dividend register doubles as the quotient register: each step
   // shifts a dividend bit out of the top and a quotient bit into the bottom.
   logic [WIDTH-1:0] dividend_sr;
   logic [WIDTH-1:0] divisor_r;
   logic [WIDTH-1:0] part_rem;
   logic [CW-1:0]    count;

   logic             load_op;
   logic             run_iter;
   logic             finish;
   logic             last_iter;

   logic [WIDTH-1:0] shifted_low;
   logic             shifted_carry;
   logic             fits;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quot_next;

   logic [WIDTH-1:0] op1_mag;
   logic [WIDTH-1:0] op2_mag;
   logic [WIDTH-1:0] quot_final;
   logic [WIDTH-1:0] rem_final;

`ifdef DIV_SIGNED_EN
   logic             quot_neg;
   logic             rem_neg;
   logic [WIDTH-1:0] dividend_orig;

   // Magnitudes feed the unsigned core; the most-negative value maps to itself,
   // which is still the correct unsigned magnitude.
   always_comb begin
      op1_mag = div_op1[WIDTH-1] ? -div_op1 : div_op1;
      op2_mag = div_op2[WIDTH-1] ? -div_op2 : div_op2;
   end

   // Restore signs on completion; a zero divisor reports the raw dividend.
   always_comb begin
      quot_final = quot_neg ? -quot_next : quot_next;
      rem_final  = rem_neg ? -rem_next : rem_next;
      if (divisor_r == '0) begin
         quot_final = '1;
         rem_final  = dividend_orig;
      end
   end

   // Sign flags and the original dividend are captured with the operands.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         quot_neg      <= 1'b0;
         rem_neg       <= 1'b0;
         dividend_orig <= '0;
      end else if (load_op) begin
         quot_neg      <= div_op1[WIDTH-1] ^ div_op2[WIDTH-1];
         rem_neg       <= div_op1[WIDTH-1];
         dividend_orig <= div_op1;
      end
   end
`else
   // Unsigned build: operands go straight into the core.
   always_comb begin
      op1_mag = div_op1;
      op2_mag = div_op2;
   end

   // Unsigned build: the core result is the final result; a zero divisor
   // naturally yields all-ones quotient and the dividend as remainder.
   always_comb begin
      quot_final = quot_next;
      rem_final  = rem_next;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: dropping div_begin aborts BUSY or releases DONE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (div_begin) next_state = BUSY;
         BUSY: begin
            if (!div_begin) begin
               next_state = IDLE;
            end else if (last_iter) begin
               next_state = DONE;
            end
         end
         DONE: if (!div_begin) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Control decode from the current state.
   always_comb begin
      last_iter = (count == CW'(WIDTH - 1));
      load_op   = (state == IDLE) && div_begin;
      run_iter  = (state == BUSY) && div_begin;
      finish    = run_iter && last_iter;
   end

   // One restoring step; the shifted remainder is WIDTH+1 bits, its top bit
   // carried separately so the subtraction stays WIDTH bits wide.
   always_comb begin
      shifted_carry = part_rem[WIDTH-1];
      shifted_low   = {part_rem[WIDTH-2:0], dividend_sr[WIDTH-1]};
      fits          = shifted_carry || (shifted_low >= divisor_r);
      rem_next      = fits ? (shifted_low - divisor_r) : shifted_low;
      quot_next     = {dividend_sr[WIDTH-2:0], fits};
   end

   // Core datapath: capture operands, then iterate while BUSY.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dividend_sr <= '0;
         divisor_r   <= '0;
         part_rem    <= '0;
         count       <= '0;
      end else if (load_op) begin
         dividend_sr <= op1_mag;
         divisor_r   <= op2_mag;
         part_rem    <= '0;
         count       <= '0;
      end else if (run_iter) begin
         dividend_sr <= quot_next;
         part_rem    <= rem_next;
         count       <= count + CW'(1);
      end
   end

   // Result registers update only on the final iteration; div_end tracks DONE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         div_end     <= 1'b0;
      end else begin
         if (finish) begin
            quotient    <= quot_final;
            remainder   <= rem_final;
            div_by_zero <= (divisor_r == '0);
         end
         div_end <= (next_state == DONE);
      end
   end

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide: a transaction-level reference model
// predicts every output on every cycle; literal checks pin the model.
module tb_divide;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             resetn = 1'b1;
   logic             div_begin = 1'b0;
   logic [WIDTH-1:0] div_op1 = '0;
   logic [WIDTH-1:0] div_op2 = '0;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             div_end;

   int checks = 0;
   int errors = 0;

   // Model state: busy flag, edges since capture, pending and visible results.
   logic             m_busy = 1'b0;
   int               m_cnt = 0;
   logic             m_end = 1'b0;
   logic [WIDTH-1:0] m_q = '0;
   logic [WIDTH-1:0] m_r = '0;
   logic             m_z = 1'b0;
   logic [WIDTH-1:0] p_q = '0;
   logic [WIDTH-1:0] p_r = '0;
   logic             p_z = 1'b0;

   divide #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .div_begin   (div_begin),
      .div_op1     (div_op1),
      .div_op2     (div_op2),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .div_end     (div_end)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Arithmetic definition of the division result.
   task automatic computeExpected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                  output logic z);
      longint sa, sb, sq, sr;
      logic [63:0] wq, wr;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         sq = sa / sb;
         sr = sa % sb;
         wq = sq;
         wr = sr;
         q  = wq[WIDTH-1:0];
         r  = wr[WIDTH-1:0];
`else
         sa = 0; sb = 0; sq = 0; sr = 0; wq = 0; wr = 0;
         q = a / b;
         r = a % b;
`endif
         z = 1'b0;
      end
   endtask

   // Reference model: capture on begin, result visible WIDTH edges later,
   // abort on early release, held until begin drops in DONE.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_busy = 1'b0;
         m_cnt  = 0;
         m_end  = 1'b0;
         m_q    = '0;
         m_r    = '0;
         m_z    = 1'b0;
      end else if (m_end) begin
         if (!div_begin) m_end = 1'b0;
      end else if (m_busy) begin
         if (!div_begin) begin
            m_busy = 1'b0;
         end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == WIDTH) begin
               m_busy = 1'b0;
               m_end  = 1'b1;
               m_q    = p_q;
               m_r    = p_r;
               m_z    = p_z;
            end
         end
      end else if (div_begin) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         computeExpected(div_op1, div_op2, p_q, p_r, p_z);
      end
   end

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      checkOutput("div_end",     WIDTH'(div_end),     WIDTH'(m_end));
      checkOutput("quotient",    quotient,            m_q);
      checkOutput("remainder",   remainder,           m_r);
      checkOutput("div_by_zero", WIDTH'(div_by_zero), WIDTH'(m_z));
   end

   // Run one division: raise begin, wait for div_end within a bound, hold
   // begin extra cycles, then release. Optionally disturb operands mid-run.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input int hold_extra, input bit disturb);
      int cycles = 0;
      @(negedge clk);
      div_op1   = a;
      div_op2   = b;
      div_begin = 1'b1;
      do begin
         @(negedge clk);
         cycles++;
         if (disturb && cycles == 5) begin
            div_op1 = 1;
            div_op2 = 1;
         end
      end while (!div_end && cycles < WIDTH + 5);
      if (!div_end) begin
         errors++;
         $display("[TB] FAIL timeout: div_end not seen after %0d cycles, expected 1", cycles);
      end else begin
         checkOutput("latency", WIDTH'(cycles - 1), WIDTH'(WIDTH));
      end
      for (int i = 0; i < hold_extra; i++) @(negedge clk);
      if (hold_extra > 0) checkOutput("held_end", WIDTH'(div_end), WIDTH'(1));
      div_begin = 1'b0;
      @(negedge clk);
      checkOutput("end_cleared", WIDTH'(div_end), WIDTH'(0));
   endtask

   initial begin
      logic [WIDTH-1:0] ra, rb;
      $display("[TB] starting divide bench");
      #1 resetn = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_q", quotient, '0);
      checkOutput("reset_end", WIDTH'(div_end), '0);
      resetn = 1'b1;

      applyStimulus(32'h64, 32'h7, 0, 1'b0);
      checkOutput("basic_q", quotient, 32'h0000000E);
      checkOutput("basic_r", remainder, 32'h00000002);
      checkOutput("basic_z", WIDTH'(div_by_zero), '0);

`ifndef DIV_SIGNED_EN
      applyStimulus(32'hFFFFFFFF, 32'h10, 0, 1'b1);
      checkOutput("large_q", quotient, 32'h0FFFFFFF);
      checkOutput("large_r", remainder, 32'h0000000F);
`endif

      applyStimulus(32'h12345678, 32'h0, 5, 1'b0);
      checkOutput("zero_q", quotient, 32'hFFFFFFFF);
      checkOutput("zero_r", remainder, 32'h12345678);
      checkOutput("zero_z", WIDTH'(div_by_zero), 32'h1);

      // Abort at iteration 10; model and per-cycle check confirm no div_end.
      @(negedge clk);
      div_op1   = 32'h1000;
      div_op2   = 32'h3;
      div_begin = 1'b1;
      repeat (10) @(negedge clk);
      div_begin = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("abort_end", WIDTH'(div_end), '0);
      checkOutput("abort_q_kept", quotient, 32'hFFFFFFFF);
      applyStimulus(32'hF, 32'h3, 0, 1'b0);
      checkOutput("restart_q", quotient, 32'h5);
      checkOutput("restart_r", remainder, 32'h0);

      // Asynchronous reset at iteration 20, between clock edges.
      @(negedge clk);
      div_op1   = 32'hABCD;
      div_op2   = 32'h7;
      div_begin = 1'b1;
      repeat (20) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      checkOutput("async_q", quotient, '0);
      checkOutput("async_r", remainder, '0);
      checkOutput("async_end", WIDTH'(div_end), '0);
      div_begin = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(32'h9, 32'h2, 0, 1'b0);
      checkOutput("post_reset_q", quotient, 32'h4);
      checkOutput("post_reset_r", remainder, 32'h1);

`ifdef DIV_SIGNED_EN
      applyStimulus(32'hFFFFFF9C, 32'h7, 0, 1'b0);
      checkOutput("s_negpos_q", quotient, 32'hFFFFFFF2);
      checkOutput("s_negpos_r", remainder, 32'hFFFFFFFE);
      applyStimulus(32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
      checkOutput("s_minneg_q", quotient, 32'h80000000);
      checkOutput("s_minneg_r", remainder, 32'h0);
      applyStimulus(32'h64, 32'hFFFFFFF9, 0, 1'b0);
      checkOutput("s_posneg_q", quotient, 32'hFFFFFFF2);
      checkOutput("s_posneg_r", remainder, 32'h2);
`endif

      // Randomized operations with mixed divisor ranges and hold times.
      for (int n = 0; n < 40; n++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = '0;
            1: rb = WIDTH'($urandom_range(1, 15));
            2: rb = $urandom >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         applyStimulus(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
